// File: rtl/dm_arbiter.sv
// dm_arbiter: round-robin two-port arbiter/sequencer for a sync-write, async-read data memory
module dm_arbiter #(
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic [AW-1:0] dm_addr,
  output logic [DW-1:0] dm_wd,
  output logic          dm_we,
  input  logic [DW-1:0] dm_rd
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state_q, state_d;
  logic rr_ptr_q, rr_ptr_d, owner_q, owner_d, we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d, m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;
  logic win, pick;
  assign win  = m0_req | m1_req;
  assign pick = (m0_req & m1_req) ? rr_ptr_q : m1_req;
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
    if (state_q == IDLE && win) begin
      owner_d  = pick;
      we_d     = pick ? m1_we : m0_we;
      addr_d   = pick ? m1_addr : m0_addr;
      wdata_d  = pick ? m1_wdata : m0_wdata;
      rr_ptr_d = ~pick;
      state_d  = ACCESS;
    end else if (state_q == ACCESS) begin
      state_d    = we_q ? IDLE : RESP;
      m0_rdata_d = (!we_q && !owner_q) ? dm_rd : m0_rdata_q;
      m1_rdata_d = (!we_q && owner_q) ? dm_rd : m1_rdata_q;
    end else if (state_q == RESP) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= 1'b0;
      owner_q    <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
    end
  end
  // rst gating keeps an aborted access invisible: no strobe and no memory commit
  assign m0_gnt    = !rst && state_q == ACCESS && !owner_q;
  assign m1_gnt    = !rst && state_q == ACCESS && owner_q;
  assign m0_rvalid = !rst && state_q == RESP && !owner_q;
  assign m1_rvalid = !rst && state_q == RESP && owner_q;
  assign dm_we     = !rst && state_q == ACCESS && we_q;
  assign dm_addr   = addr_q;
  assign dm_wd     = wdata_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;
endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the 32x32 single-port data memory: synchronous write, asynchronous read.
- Port 0 is the core load/store unit. Port 1 is the debug/program-loader port.
- Grants one access at a time with round-robin fairness, drives the memory's address/write-data/write-enable, and returns registered read data with a valid pulse.

Parameters:
- AW, 5, memory address width (32 words).
- DW, 32, data width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-high reset.
- m0_req  input  1  port 0 request; held with fields stable until m0_gnt seen.
- m0_we  input  1  port 0 access type: 1 = write, 0 = read.
- m0_addr  input  AW  port 0 word address.
- m0_wdata  input  DW  port 0 write data.
- m0_gnt  output  1  one-cycle pulse: port 0 request accepted and being performed.
- m0_rvalid  output  1  one-cycle pulse: m0_rdata valid.
- m0_rdata  output  DW  port 0 read data, registered.
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as port 0, for port 1.
- dm_addr  output  AW  memory address.
- dm_wd  output  DW  memory write data.
- dm_we  output  1  memory write enable.
- dm_rd  input  DW  memory asynchronous read data.

Behaviour:
- Single clock domain (clk). Reset is synchronous and active-high.
- Reset values: state=IDLE, rr_ptr=0, all gnt/rvalid=0, m0_rdata=m1_rdata=0, latched addr/wdata/we/owner=0.
- dm_we is gated combinationally by !rst, so a write in flight when rst rises is not committed.
- FSM states: IDLE, ACCESS, RESP.
- IDLE: samples m0_req/m1_req each edge.
  - Neither asserted: stay in IDLE.
  - Exactly one asserted: that port wins.
  - Both asserted: the port equal to rr_ptr wins.
  - On a win: latch owner, we, addr, wdata; rr_ptr <= ~owner; go to ACCESS.
- ACCESS (exactly one cycle):
  - dm_addr = latched addr.
  - dm_wd = latched wdata.
  - dm_we = latched we.
  - gnt of owner = 1.
  - Requests are not sampled.
  - Read: capture dm_rd into owner's rdata at the end of the cycle, go to RESP.
  - Write: go to IDLE. Memory commits at the edge ending ACCESS.
- RESP (one cycle): owner's rvalid = 1, then go to IDLE.
- Outside ACCESS: dm_we=0. dm_addr/dm_wd hold their latched values; no other requirement.
- Handshake:
  - The requester may deassert req or change fields at the edge ending the gnt cycle.
  - req must not drop before gnt. If it does, behaviour is undefined only when the request was not yet sampled.
  - gnt is registered-state driven, never combinational from req.
- Latency, counted from the sampling edge E0 in IDLE:
  - gnt is high in cycle E0..E1.
  - Write is visible in memory after E1.
  - Read: rvalid is high in cycle E1..E2.
- Throughput: writes 1 per 2 cycles; reads 1 per 3 cycles.
- rdata: holds its value after rvalid until the next read by that port. The other port's rdata is never modified.
- Fairness: with both requesting continuously, grants alternate 0,1,0,1... Neither port waits more than one other access.
- rr_ptr advances only on a grant, never on idle cycles.
- Ordering: accesses are strictly serialised. A read granted after a write to the same address returns the new data.
- Address wrap: none. AW covers the whole memory; every address is legal.
- Reset mid-operation: any state returns to IDLE at the next edge with rst high.
  - No gnt or rvalid is emitted for the aborted access.
  - A requester whose request was aborted must re-request; its req still high is simply re-sampled after reset.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, no req -> all gnt/rvalid=0, dm_we=0, m0_rdata=m1_rdata=0.
- Port 0 write then read: m0 write addr=5, wdata=0xDEADBEEF.
  - Expect m0_gnt 1 cycle after sampling, with dm_we=1, dm_addr=5 in that cycle.
  - Then m0 read addr=5 -> m0_rvalid 2 cycles after sampling, with m0_rdata=0xDEADBEEF.
  - m1_rdata stays 0.
- Contention round-robin: both req reads continuously from reset (m0 addr=1, m1 addr=2, memory preloaded 0x11/0x22).
  - Expect grant order m0,m1,m0,m1.
  - Expect m0_rdata=0x11, m1_rdata=0x22, each rvalid exactly once per grant.
- Cross-port ordering: m1 write addr=7, wdata=0xA5A5A5A5 and m0 read addr=7 asserted same cycle, rr_ptr=1.
  - Expect the m1 write first.
  - Then m0 read returns 0xA5A5A5A5.
- Reset mid-write: m0 write addr=3, wdata=0x12345678, with rst asserted in the ACCESS cycle.
  - Expect dm_we=0, no m0_gnt, MEM[3] unchanged, state IDLE.
  - With m0_req still high after reset, the write is re-granted and then MEM[3]=0x12345678.
- Lone requester ignores pointer: rr_ptr=0, only m1 requests -> m1 granted immediately; rr_ptr becomes 0 afterwards.
